mem_responder: RTL

- Memory-side responder for the datapath's MAR/MDR memory interface.
- Accepts a Read or Write request with an address (from MAR) and write data (from MDR).
- Performs the access against an internal word-addressed RAM after a programmable number of wait states.
- Returns read data on Mdatain (the MDR input-mux memory leg) and pulses MemDone, so the control unit can hold the Read/MDRin step until data is valid.

---
 rtl/cpu_mem_pkg.sv | 14 +
 rtl/ram_sp_32.sv | 24 ++
 rtl/mem_responder.sv | 107 ++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types and constants for the memory responder
package cpu_mem_pkg;

    localparam int WORD_W        = 32;
    localparam int DEF_ADDR_BITS = 9;
    localparam int CNT_W         = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/ram_sp_32.sv
// rtl/ram_sp_32.sv - single-port synchronous 32-bit RAM, read-first
module ram_sp_32
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);

    logic [WORD_W-1:0] mem [0:(2**ADDR_BITS)-1];

    // Registered read returns the contents before any same-edge write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - MAR/MDR memory responder with programmable wait states
module mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_BITS   = DEF_ADDR_BITS,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [WORD_W-1:0] MAR_addr,
    input  logic [WORD_W-1:0] MDR_wdata,
    input  logic              Read,
    input  logic              Write,
    output logic [WORD_W-1:0] Mdatain,
    output logic              MemDone,
    output logic              MemErr,
    output logic              Busy
);

    mem_state_t           state;
    logic [CNT_W-1:0]     cnt;
    logic                 op_rd;
    logic                 err_q;
    logic [WORD_W-1:0]    addr_q;
    logic [WORD_W-1:0]    wdata_q;

    logic                 out_of_range;
    logic                 access;
    logic                 ram_we;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [WORD_W-1:0]    ram_rdata;

    // Any set address bit above the decoded range makes the access illegal.
    assign out_of_range = |addr_q[WORD_W-1:ADDR_BITS];
    assign access       = (state == ST_BUSY) && (cnt == '0);

    // The RAM is addressed from MAR while idle so read data is already valid
    // by the access edge, even with zero wait states. A reset on the access
    // edge must suppress the write, hence the clr term.
    assign ram_addr = (state == ST_IDLE) ? MAR_addr[ADDR_BITS-1:0]
                                         : addr_q[ADDR_BITS-1:0];
    assign ram_we   = clr && access && !op_rd && !out_of_range;

    ram_sp_32 #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // Request FSM: latch request, count wait states, access, pulse done.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            op_rd   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            Mdatain <= '0;
            MemDone <= 1'b0;
            MemErr  <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    MemDone <= 1'b0;
                    MemErr  <= 1'b0;
                    if (Read || Write) begin
                        op_rd   <= Read;
                        err_q   <= Read && Write;
                        addr_q  <= MAR_addr;
                        wdata_q <= MDR_wdata;
                        cnt     <= CNT_W'(WAIT_CYCLES);
                        Busy    <= 1'b1;
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (op_rd) begin
                            Mdatain <= out_of_range ? '0 : ram_rdata;
                        end
                        MemDone <= 1'b1;
                        MemErr  <= err_q || out_of_range;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    MemDone <= 1'b0;
                    MemErr  <= 1'b0;
                    Busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
